// File: rtl/matrix_mac_sequencer_if.sv
// Purpose: bundles the host load path, run control, MAC drive and result port of the sequencer.
// Latency: none, wiring only.
// Backpressure: ld_ready gates operand writes; res_ready stalls the result port.
interface matrix_mac_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4,
  parameter int DIM_MAX    = 4
);
  localparam int AW = $clog2(DIM_MAX*DIM_MAX);
  localparam int IW = $clog2(DIM_MAX);
  localparam int NW = $clog2(DIM_MAX)+1;

  // host operand load path
  logic                  ld_valid;
  logic                  ld_sel;
  logic [AW-1:0]         ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;

  // run control
  logic                  start;
  logic [NW-1:0]         dim;
  logic                  busy;
  logic                  done;

  // MAC datapath drive and accumulator feedback
  logic                  mac_clear;
  logic                  mac_enable;
  logic [DATA_WIDTH-1:0] mac_op_a;
  logic [DATA_WIDTH-1:0] mac_op_b;
  logic [ACC_WIDTH-1:0]  mac_result;

  // result stream
  logic                  res_valid;
  logic                  res_ready;
  logic [IW-1:0]         res_row;
  logic [IW-1:0]         res_col;
  logic [ACC_WIDTH-1:0]  res_data;

  // sequencer side
  modport slave (
    input  ld_valid, ld_sel, ld_addr, ld_data, start, dim, mac_result, res_ready,
    output ld_ready, busy, done, mac_clear, mac_enable, mac_op_a, mac_op_b,
           res_valid, res_row, res_col, res_data
  );

  // host / MAC / sink side
  modport master (
    output ld_valid, ld_sel, ld_addr, ld_data, start, dim, mac_result, res_ready,
    input  ld_ready, busy, done, mac_clear, mac_enable, mac_op_a, mac_op_b,
           res_valid, res_row, res_col, res_data
  );
endinterface

// File: rtl/matrix_mac_sequencer.sv
// Purpose: holds operand matrices A and B, sequences the MAC unit per dot product, streams C=A*B row-major.
// Latency: N+3 cycles per element (CLEAR, N x MAC, DRAIN, OUT) with res_ready held high; done one cycle after the last handshake.
// Backpressure: res_ready low freezes the FSM in OUT with all outputs held; loads are refused while busy.
module matrix_mac_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4,
  parameter int DIM_MAX    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_mac_sequencer_if.slave  bus
);
  localparam int DEPTH = DIM_MAX*DIM_MAX;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = $clog2(DIM_MAX);
  localparam int NW    = $clog2(DIM_MAX)+1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_DRAIN,
    S_OUT,
    S_FIN
  } state_t;

  state_t                state_q, state_d;
  logic [NW-1:0]         n_q, n_d;
  logic [IW-1:0]         i_q, i_d;
  logic [IW-1:0]         j_q, j_d;
  logic [IW-1:0]         k_q, k_d;
  logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;
  logic [IW-1:0]         res_row_q, res_row_d;
  logic [IW-1:0]         res_col_q, res_col_d;

  // Operand storage: plain registers, deliberately without reset so contents survive runs.
  logic [DATA_WIDTH-1:0] a_mem [DEPTH];
  logic [DATA_WIDTH-1:0] b_mem [DEPTH];

  logic                  busy_w;
  logic                  wr_en;
  logic [AW-1:0]         rd_a_addr;
  logic [AW-1:0]         rd_b_addr;
  logic                  last_k;
  logic                  last_i;
  logic                  last_j;
  logic [NW-1:0]         dim_clamped;

  assign busy_w = (state_q == S_CLEAR) || (state_q == S_MAC) ||
                  (state_q == S_DRAIN) || (state_q == S_OUT);
  assign wr_en  = bus.ld_valid && !busy_w;

  // A[i][k] and B[k][j] in the row*DIM_MAX+col layout used by the load path.
  assign rd_a_addr = AW'(int'(i_q) * DIM_MAX + int'(k_q));
  assign rd_b_addr = AW'(int'(k_q) * DIM_MAX + int'(j_q));

  // n_q is never zero outside IDLE/FIN, so n_q-1 is a valid last index.
  assign last_k = ({1'b0, k_q} == (n_q - NW'(1)));
  assign last_i = ({1'b0, i_q} == (n_q - NW'(1)));
  assign last_j = ({1'b0, j_q} == (n_q - NW'(1)));

  assign dim_clamped = (bus.dim > NW'(DIM_MAX)) ? NW'(DIM_MAX) : bus.dim;

  // Operand write port; a write in the same IDLE cycle as start lands before CLEAR reads it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (bus.ld_sel) begin
        b_mem[bus.ld_addr] <= bus.ld_data;
      end else begin
        a_mem[bus.ld_addr] <= bus.ld_data;
      end
    end
  end

  // State, counters and result holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      res_data_q <= '0;
      res_row_q  <= '0;
      res_col_q  <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      res_data_q <= res_data_d;
      res_row_q  <= res_row_d;
      res_col_q  <= res_col_d;
    end
  end

  // Next-state sequencing: one CLEAR/MAC.../DRAIN/OUT pass per element of C.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    res_data_d = res_data_q;
    res_row_d  = res_row_q;
    res_col_d  = res_col_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.dim == '0) begin
            state_d = S_FIN;
          end else begin
            n_d     = dim_clamped;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_MAC;
      end
      S_MAC: begin
        if (last_k) begin
          k_d     = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      S_DRAIN: begin
        // The final enable from MAC is visible on mac_result this cycle.
        res_data_d = bus.mac_result;
        res_row_d  = i_q;
        res_col_d  = j_q;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (bus.res_ready) begin
          if (last_i && last_j) begin
            state_d = S_FIN;
          end else begin
            if (last_j) begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + IW'(1);
            end
            state_d = S_CLEAR;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode; operands are forced to zero whenever the MAC is not accumulating.
  always_comb begin
    bus.busy       = busy_w;
    bus.ld_ready   = !busy_w;
    bus.done       = (state_q == S_FIN);
    bus.mac_clear  = (state_q == S_CLEAR);
    bus.mac_enable = (state_q == S_MAC);
    bus.mac_op_a   = '0;
    bus.mac_op_b   = '0;
    if (state_q == S_MAC) begin
      bus.mac_op_a = a_mem[rd_a_addr];
      bus.mac_op_b = b_mem[rd_b_addr];
    end
    bus.res_valid  = (state_q == S_OUT);
    bus.res_data   = res_data_q;
    bus.res_row    = res_row_q;
    bus.res_col    = res_col_q;
  end

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Purpose: drives loads and runs into matrix_mac_sequencer, models the MAC unit, scores C against a matrix model.
// Latency: checks first-result and done cycles against N+3 and N*N*(N+3)+1 when the sink never stalls.
// Backpressure: sink ready is held, toggled or randomised; stalled results must hold every output.
module tb_matrix_mac_sequencer;
  localparam int DW   = 8;
  localparam int ACCW = 2*DW+4;
  localparam int DM   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_mac_sequencer_if #(.DATA_WIDTH(DW), .ACC_WIDTH(ACCW), .DIM_MAX(DM)) bus ();

  matrix_mac_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(ACCW), .DIM_MAX(DM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural MAC unit: accumulator updates on the edge, so results lag enable by one cycle.
  logic [ACCW-1:0] acc;
  always @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else if (bus.mac_clear) acc <= '0;
    else if (bus.mac_enable) acc <= acc + ACCW'(bus.mac_op_a) * ACCW'(bus.mac_op_b);
  end
  assign bus.mac_result = acc;

  int n_chk  = 0;
  int n_pass = 0;
  int a_m [DM*DM];
  int b_m [DM*DM];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ld_ready"}, bus.ld_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_mac_clear"}, bus.mac_clear, 0);
    chk({tag, "_mac_enable"}, bus.mac_enable, 0);
    chk({tag, "_ops"}, {bus.mac_op_a, bus.mac_op_b}, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_data"}, bus.res_data, 0);
    chk({tag, "_res_idx"}, {bus.res_row, bus.res_col}, 0);
  endtask

  task automatic load(input bit sel, input int addr, input int data);
    bus.ld_valid = 1'b1;
    bus.ld_sel   = sel;
    bus.ld_addr  = 4'(addr);
    bus.ld_data  = 8'(data);
    step();
    bus.ld_valid = 1'b0;
  endtask

  // Push the whole model contents of both matrices into the DUT.
  task automatic load_model();
    for (int a = 0; a < DM*DM; a++) begin
      load(1'b0, a, a_m[a]);
      load(1'b1, a, b_m[a]);
    end
  endtask

  // One multiply: start at edge 0, then observe cycles 1.. until done or budget exhausted.
  task automatic run(input int dim_req, input int rmode, input bit poke,
                     input int sw_addr, input int sw_val);
    int n, cyc, nres, first_vld, done_cyc;
    longint expq[$];
    int rowq[$];
    int colq[$];
    bit prev_stall, rdy, clr_en_bad, op_bad;
    longint pd;
    int pr, pc;
    n = (dim_req > DM) ? DM : dim_req;
    if (sw_addr >= 0) a_m[sw_addr] = sw_val;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        longint s = 0;
        for (int k = 0; k < n; k++) s += longint'(a_m[i*DM+k]) * longint'(b_m[k*DM+j]);
        expq.push_back(s);
        rowq.push_back(i);
        colq.push_back(j);
      end
    bus.start = 1'b1;
    bus.dim   = 3'(dim_req);
    if (sw_addr >= 0) begin
      bus.ld_valid = 1'b1;
      bus.ld_sel   = 1'b0;
      bus.ld_addr  = 4'(sw_addr);
      bus.ld_data  = 8'(sw_val);
    end
    step();
    bus.start    = 1'b0;
    bus.ld_valid = 1'b0;
    cyc = 1; nres = 0; first_vld = -1; done_cyc = -1;
    prev_stall = 0; clr_en_bad = 0; op_bad = 0; pd = 0; pr = 0; pc = 0;
    while (cyc < 2000) begin
      if (bus.mac_clear && bus.mac_enable) clr_en_bad = 1;
      if (!bus.mac_enable && (bus.mac_op_a != 0 || bus.mac_op_b != 0)) op_bad = 1;
      if (cyc == 1) chk("busy_c1", bus.busy, (n > 0) ? 1 : 0);
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (bus.res_valid && first_vld < 0) first_vld = cyc;
      if (prev_stall) begin
        chk("hold_valid", bus.res_valid, 1);
        chk("hold_data", bus.res_data, pd);
        chk("hold_idx", bus.res_row * 16 + bus.res_col, pr * 16 + pc);
      end
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      bus.res_ready = rdy;
      if (poke && cyc == 3) begin
        bus.ld_valid = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = '0;
        bus.ld_data  = 8'(~a_m[0]); bus.start = 1'b1; bus.dim = 3'd4;
      end
      if (poke && cyc == 4) begin
        bus.ld_valid = 1'b0;
        bus.start    = 1'b0;
      end
      if (bus.res_valid) begin
        if (rdy) begin
          if (expq.size() > 0) begin
            chk("res_data", bus.res_data, expq.pop_front());
            chk("res_row", bus.res_row, rowq.pop_front());
            chk("res_col", bus.res_col, colq.pop_front());
          end
          nres++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          pd = bus.res_data; pr = bus.res_row; pc = bus.res_col;
        end
      end else begin
        prev_stall = 0;
      end
      step();
      cyc++;
    end
    bus.res_ready = 1'b0;
    chk("done_seen", (done_cyc >= 0) ? 1 : 0, 1);
    chk("res_count", nres, n*n);
    chk("clr_en_exclusive", clr_en_bad, 0);
    chk("ops_zero_idle", op_bad, 0);
    if (n == 0) chk("dim0_done_cycle", done_cyc, 1);
    if (rmode == 0 && n > 0) begin
      chk("first_valid_cycle", first_vld, n + 3);
      chk("done_cycle", done_cyc, n*n*(n+3) + 1);
    end
    step();
    chk("done_pulse", bus.done, 0);
    chk("idle_after", bus.busy, 0);
  endtask

  initial begin
    bit bad;
    bus.ld_valid = 1'b0; bus.ld_sel = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.start = 1'b0; bus.dim = '0; bus.res_ready = 1'b0;
    rst = 1'b1;
    step(); step();
    check_quiet("reset");
    rst = 1'b0;
    step();

    // A = I2, B = [[1,2],[3,4]], everything else zero.
    for (int a = 0; a < DM*DM; a++) begin a_m[a] = 0; b_m[a] = 0; end
    a_m[0] = 1; a_m[5] = 1;
    b_m[0] = 1; b_m[1] = 2; b_m[4] = 3; b_m[5] = 4;
    load_model();
    run(2, 0, 0, -1, 0);
    run(2, 1, 0, -1, 0);

    // Corner case for accumulator width: all 255 at full dimension.
    for (int a = 0; a < DM*DM; a++) begin a_m[a] = 255; b_m[a] = 255; end
    load_model();
    run(4, 0, 0, -1, 0);
    run(0, 0, 0, -1, 0);
    run(7, 0, 0, -1, 0);

    // Reset during MAC of element (0,1): cycle 6 is its CLEAR, cycle 7 its first MAC.
    for (int a = 0; a < DM*DM; a++) begin a_m[a] = $urandom_range(0, 255); b_m[a] = $urandom_range(0, 255); end
    load_model();
    bus.start = 1'b1; bus.dim = 3'd2;
    step();
    bus.start = 1'b0; bus.res_ready = 1'b1;
    for (int c = 1; c < 7; c++) step();
    chk("mac_before_reset", bus.mac_enable, 1);
    rst = 1'b1;
    #1;
    check_quiet("abort");
    step();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done || bus.res_valid || bus.busy) bad = 1;
      step();
    end
    bus.res_ready = 1'b0;
    chk("abort_silent", bad, 0);
    run(2, 0, 0, -1, 0);

    // Writes and start while busy are ignored; the rerun proves A[0] is untouched.
    run(2, 0, 1, -1, 0);
    run(2, 2, 0, -1, 0);

    // Write and start in the same IDLE cycle: the new A[0] is used.
    run(2, 0, 0, 0, (a_m[0] + 77) % 256);

    // Randomised matrices, dimensions and sink backpressure.
    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < DM*DM; a++) begin a_m[a] = $urandom_range(0, 255); b_m[a] = $urandom_range(0, 255); end
      load_model();
      run(int'($urandom_range(1, 5)), 2, 0, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
